// File: rtl/spi_slv_pkg.sv
// Shared types and constants for the mode-0 SPI slave.
package spi_slv_pkg;

  // Transfer FSM states; IDLE is the reset state.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } spi_state_e;

  // Flops in each pin synchronizer chain (edge detector flop is extra).
  localparam int unsigned SyncDepth = 2;

  // Minimum sclk high/low phase in clk periods; must exceed sync + edge latency.
  localparam int unsigned MinSclkHalf = 4;

endpackage

// File: rtl/spi_slave_sync.sv
// Pin synchronizer with one-cycle rise/fall pulses for an asynchronous SPI pin.
// Runs regardless of the slave's enable so edges keep flowing through the chain.
module spi_slave_sync
  import spi_slv_pkg::*;
#(
  parameter int unsigned Depth    = SyncDepth,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [Depth-1:0] r_sync;
  logic             r_prev;

  // Synchronizer chain plus the delayed copy used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {Depth{ResetVal}};
      r_prev <= ResetVal;
    end else begin
      r_sync <= {r_sync[Depth-2:0], i_pin};
      r_prev <= r_sync[Depth-1];
    end
  end

  assign o_level = r_sync[Depth-1];
  assign o_rise  = r_sync[Depth-1] & ~r_prev;
  assign o_fall  = ~r_sync[Depth-1] & r_prev;

endmodule

// File: rtl/spi_slave.sv
// Oversampled SPI mode-0 slave exchanging one word of 1..DW bits per go command.
// Optional feature macro: SPI_SLV_LSB_FIRST_EN (bit 0 shifted first on miso and mosi).
module spi_slave
  import spi_slv_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned LOG2_DW = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sm_ena,
  input  logic [LOG2_DW-1:0] cBITS_PER_WORD,
  input  logic               go,
  input  logic [DW-1:0]      tx_data,
  output logic [DW-1:0]      rx_data,
  output logic               ret_r,
  output logic               busy,
  input  logic               sclk,
  input  logic               cs_n,
  input  logic               mosi,
  output logic               miso
);

  // One extra bit so the count and word length can hold DW itself.
  localparam int unsigned CntW = LOG2_DW + 1;

  spi_state_e r_state, w_state_next;

  logic [CntW-1:0] r_n;
  logic [CntW-1:0] r_cnt;
  logic [DW-1:0]   r_tx_word;
  logic [DW-1:0]   r_tx_sh;
  logic [DW-1:0]   r_rx_sh;
  logic [DW-1:0]   r_rx_data;
  logic            r_ret;

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
  logic w_unused_edges;

  logic [CntW-1:0] w_n;
  logic [DW-1:0]   w_tx_load;
  logic [DW-1:0]   w_tx_shift;
  logic            w_tx_bit;
  logic [DW-1:0]   w_rx_next;
  logic [DW-1:0]   w_rx_word;
  logic            w_go_acc;
  logic            w_last;

  spi_slave_sync #(
    .Depth   (SyncDepth),
    .ResetVal(1'b0)
  ) u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pin  (sclk),
    .o_level(w_sclk_lvl),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // cs_n idles high; resetting its chain high avoids a phantom select at startup.
  spi_slave_sync #(
    .Depth   (SyncDepth),
    .ResetVal(1'b1)
  ) u_sync_cs (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pin  (cs_n),
    .o_level(w_cs_lvl),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  spi_slave_sync #(
    .Depth   (SyncDepth),
    .ResetVal(1'b0)
  ) u_sync_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pin  (mosi),
    .o_level(w_mosi_lvl),
    .o_rise (w_mosi_rise),
    .o_fall (w_mosi_fall)
  );

  // Select is acted on by level so a master already holding cs_n low still starts.
  assign w_unused_edges = ^{w_sclk_lvl, w_cs_rise, w_cs_fall, w_mosi_rise, w_mosi_fall};

  assign w_n      = (cBITS_PER_WORD == '0) ? CntW'(DW) : CntW'(cBITS_PER_WORD);
  assign w_go_acc = go & ((r_state == StIdle) | (r_state == StDone));
  assign w_last   = ((r_cnt + CntW'(1)) == r_n);

`ifdef SPI_SLV_LSB_FIRST_EN
  logic [CntW-1:0] w_rx_shamt;
  // Word kept right-aligned; shift out of bit 0, shift in at the top.
  assign w_tx_load  = tx_data;
  assign w_tx_bit   = r_tx_sh[0];
  assign w_tx_shift = {1'b0, r_tx_sh[DW-1:1]};
  assign w_rx_next  = {w_mosi_lvl, r_rx_sh[DW-1:1]};
  assign w_rx_shamt = CntW'(DW) - r_n;
  assign w_rx_word  = w_rx_next >> w_rx_shamt;
`else
  logic [CntW-1:0] w_tx_shamt;
  // Word left-aligned at load so bit N-1 always sits at the shifter MSB.
  assign w_tx_shamt = CntW'(DW) - w_n;
  assign w_tx_load  = tx_data << w_tx_shamt;
  assign w_tx_bit   = r_tx_sh[DW-1];
  assign w_tx_shift = {r_tx_sh[DW-2:0], 1'b0};
  assign w_rx_next  = {r_rx_sh[DW-2:0], w_mosi_lvl};
  assign w_rx_word  = w_rx_next;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; everything holds while sm_ena is low.
  always_comb begin
    w_state_next = r_state;
    if (sm_ena) begin
      case (r_state)
        StIdle:  if (go) w_state_next = StArmed;
        StArmed: if (!w_cs_lvl) w_state_next = StShift;
        StShift: begin
          if (w_cs_lvl) begin
            w_state_next = StArmed;
          end else if (w_sclk_rise && w_last) begin
            w_state_next = StDone;
          end
        end
        StDone:  if (go) w_state_next = StArmed;
        default: w_state_next = StIdle;
      endcase
    end
  end

  // FSM outputs: busy while waiting for or shifting a word, miso only driven in SHIFT.
  always_comb begin
    busy = 1'b0;
    miso = 1'b0;
    case (r_state)
      StArmed: busy = 1'b1;
      StShift: begin
        busy = 1'b1;
        miso = w_tx_bit;
      end
      default: ;
    endcase
  end

  // Datapath: go loading, shifters, bit counter and completion capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n       <= '0;
      r_cnt     <= '0;
      r_tx_word <= '0;
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_ret     <= 1'b0;
    end else if (sm_ena) begin
      if (w_go_acc) begin
        r_n       <= w_n;
        r_tx_word <= w_tx_load;
        r_tx_sh   <= w_tx_load;
        r_cnt     <= '0;
        r_ret     <= 1'b0;
      end else begin
        case (r_state)
          StArmed: begin
            // Fresh start on every entry to SHIFT, including after an abort.
            if (!w_cs_lvl) begin
              r_cnt   <= '0;
              r_rx_sh <= '0;
            end
          end
          StShift: begin
            if (w_cs_lvl) begin
              r_tx_sh <= r_tx_word;
            end else if (w_sclk_rise) begin
              r_rx_sh <= w_rx_next;
              r_cnt   <= r_cnt + CntW'(1);
              if (w_last) begin
                r_rx_data <= w_rx_word;
                r_ret     <= 1'b1;
              end
            end else if (w_sclk_fall) begin
              r_tx_sh <= w_tx_shift;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_data = r_rx_data;
  assign ret_r   = r_ret;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: vector table, hand-written corner sequences and
// randomized words checked against a word-level model (rx = master word masked to N bits,
// miso word = tx word masked to N bits). Honours SPI_SLV_LSB_FIRST_EN for bit order.
module tb_spi_slave;

  localparam int H = 8;  // sclk half-period in clk cycles

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        sm_ena  = 1'b1;
  logic [4:0]  cbits   = '0;
  logic        go      = 1'b0;
  logic [31:0] tx_data = '0;
  logic [31:0] rx_data;
  logic        ret_r;
  logic        busy;
  logic        sclk    = 1'b0;
  logic        cs_n    = 1'b1;
  logic        mosi    = 1'b0;
  logic        miso;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] last_rx;
  logic [31:0] mw;
  logic [31:0] mw_rst;

  typedef struct {
    logic [4:0]  bits;
    logic [31:0] tx;
    logic [31:0] md;
    logic [31:0] exp_rx;
    logic [31:0] exp_miso;
  } vec_t;

  vec_t vecs[6];

  spi_slave #(
    .DW     (32),
    .LOG2_DW(5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sm_ena        (sm_ena),
    .cBITS_PER_WORD(cbits),
    .go            (go),
    .tx_data       (tx_data),
    .rx_data       (rx_data),
    .ret_r         (ret_r),
    .busy          (busy),
    .sclk          (sclk),
    .cs_n          (cs_n),
    .mosi          (mosi),
    .miso          (miso)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mask_of(input int n);
    logic [31:0] one;
    one = 32'h1;
    return (n >= 32) ? 32'hFFFF_FFFF : ((one << n) - 32'h1);
  endfunction

  // Position within the word of the i-th bit on the wire.
  function automatic int bit_pos(input int n, input int i);
`ifdef SPI_SLV_LSB_FIRST_EN
    return i + 0 * n;
`else
    return n - 1 - i;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_go(input logic [4:0] b, input logic [31:0] tx);
    @(negedge clk);
    cbits   = b;
    tx_data = tx;
    go      = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("busy after go", 32'(busy), 32'd1);
  endtask

  // Mode-0 master: n bits of md, abort (cs_n high) after abort_after bits when >= 0.
  task automatic spi_xfer(input int n, input logic [31:0] md, input int abort_after,
                          output logic [31:0] mword);
    mword = '0;
    @(negedge clk);
    cs_n = 1'b0;
    mosi = md[bit_pos(n, 0)];
    repeat (H) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i == abort_after) break;
      mword[bit_pos(n, i)] = miso;
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
      if (i + 1 < n) mosi = md[bit_pos(n, i + 1)];
      repeat (H) @(negedge clk);
    end
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{5'd16, 32'h0000_A5C3, 32'h0000_3C5A, 32'h0000_3C5A, 32'h0000_A5C3};
    vecs[1] = '{5'd0,  32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[2] = '{5'd1,  32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
    vecs[3] = '{5'd8,  32'hFFFF_FF5A, 32'h0000_0123, 32'h0000_0023, 32'h0000_005A};
    vecs[4] = '{5'd31, 32'h8000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001};
    vecs[5] = '{5'd2,  32'h0000_0002, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002};

    // Reset values.
    #99 rst_n = 1'b1;
    #500;
    check("reset ret_r", 32'(ret_r), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset miso", 32'(miso), 32'd0);
    check("reset rx_data", rx_data, 32'd0);

    // Vector table.
    foreach (vecs[k]) begin
      do_go(vecs[k].bits, vecs[k].tx);
      spi_xfer((vecs[k].bits == 0) ? 32 : int'(vecs[k].bits), vecs[k].md, -1, mw);
      check("vec rx_data", rx_data, vecs[k].exp_rx);
      check("vec miso word", mw, vecs[k].exp_miso);
      check("vec ret_r", 32'(ret_r), 32'd1);
      check("vec busy done", 32'(busy), 32'd0);
      check("vec miso idle", 32'(miso), 32'd0);
    end
    last_rx = vecs[5].exp_rx;

    // go while ARMED must not reload N or tx data.
    do_go(5'd8, 32'h0000_005A);
    @(negedge clk);
    cbits   = 5'd16;
    tx_data = 32'h0000_FFFF;
    go      = 1'b1;
    @(negedge clk);
    go = 1'b0;
    spi_xfer(8, 32'h0000_00C3, -1, mw);
    check("busy-go rx_data", rx_data, 32'h0000_00C3);
    check("busy-go miso word", mw, 32'h0000_005A);
    check("busy-go ret_r", 32'(ret_r), 32'd1);
    last_rx = 32'h0000_00C3;

    // go in DONE clears ret_r on the accepting edge.
    @(negedge clk);
    cbits   = 5'd16;
    tx_data = 32'h0000_A5C3;
    go      = 1'b1;
    @(posedge clk);
    #1;
    check("done-go ret_r cleared", 32'(ret_r), 32'd0);
    check("done-go busy", 32'(busy), 32'd1);
    @(negedge clk);
    go = 1'b0;

    // Abort after 5 bits, then a full word.
    spi_xfer(16, 32'h0000_1111, 5, mw);
    check("abort busy (armed)", 32'(busy), 32'd1);
    check("abort ret_r", 32'(ret_r), 32'd0);
    check("abort rx_data held", rx_data, last_rx);
    check("abort miso", 32'(miso), 32'd0);
    spi_xfer(16, 32'h0000_3C5A, -1, mw);
    check("post-abort rx_data", rx_data, 32'h0000_3C5A);
    check("post-abort miso word", mw, 32'h0000_A5C3);
    check("post-abort ret_r", 32'(ret_r), 32'd1);
    last_rx = 32'h0000_3C5A;

    // Stall mid-word: dropped edges leave the word short, so no completion.
    do_go(5'd16, 32'h0000_00F0);
    fork
      spi_xfer(16, 32'h0000_BEEF, -1, mw);
      begin
        repeat (H + 2 * H * 3 + 4) @(negedge clk);
        sm_ena = 1'b0;
        repeat (20) @(negedge clk);
        check("stall busy", 32'(busy), 32'd1);
        check("stall ret_r", 32'(ret_r), 32'd0);
        sm_ena = 1'b1;
      end
    join
    check("stall no completion", 32'(ret_r), 32'd0);
    check("stall busy after", 32'(busy), 32'd1);
    check("stall rx_data held", rx_data, last_rx);
    spi_xfer(16, 32'h0000_5A5A, -1, mw);
    check("post-stall rx_data", rx_data, 32'h0000_5A5A);
    check("post-stall miso word", mw, 32'h0000_00F0);
    check("post-stall ret_r", 32'(ret_r), 32'd1);

    // Randomized words against the word-level model.
    for (int k = 0; k < 8; k++) begin
      logic [4:0]  b;
      logic [31:0] tx, md;
      int          n;
      b  = 5'($urandom_range(0, 31));
      tx = $urandom;
      md = $urandom;
      n  = (b == 0) ? 32 : int'(b);
      do_go(b, tx);
      spi_xfer(n, md, -1, mw);
      check("rand rx_data", rx_data, md & mask_of(n));
      check("rand miso word", mw, tx & mask_of(n));
      check("rand ret_r", 32'(ret_r), 32'd1);
    end

    // Reset in the middle of a full-width word.
    do_go(5'd0, 32'hCAFE_F00D);
    fork
      spi_xfer(32, 32'h0F0F_0F0F, -1, mw_rst);
      begin
        repeat (H + 60) @(negedge clk);
        check("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid-reset busy", 32'(busy), 32'd0);
        check("mid-reset miso", 32'(miso), 32'd0);
        check("mid-reset ret_r", 32'(ret_r), 32'd0);
        check("mid-reset rx_data", rx_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    check("post-reset idle busy", 32'(busy), 32'd0);
    check("post-reset ret_r", 32'(ret_r), 32'd0);
    do_go(5'd12, 32'h0000_0ABC);
    spi_xfer(12, 32'h0000_0555, -1, mw);
    check("recovery rx_data", rx_data, 32'h0000_0555);
    check("recovery miso word", mw, 32'h0000_0ABC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
